pri_dec_2: RTL and testbench

Sequential decoder for the two-index priority code (`y1`/`idle1` for the highest set bit, `y2`/`idle2` for the second highest). It accepts a stream of code beats over a valid/ready handshake and rebuilds the original request vector by OR-ing each decoded beat into an accumulator. On the beat marked last, it presents the rebuilt vector, its population count and error flags on a held output port. It sits at the receiving end of any link that carries priority-encoded requests, and it lets a bench round-trip vectors through the encoder.

---
 rtl/pri_dec_2.sv | 119 +++++++++++
 tb/tb_pri_dec_2.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pri_dec_2.sv
// Rebuilds a request vector from a stream of two-index priority code beats.
// The result (vector, popcount, dup/err flags) appears the cycle after the last beat and holds until taken.
module pri_dec_2 #(
    parameter int W  = 8,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] y1,
    input  logic [IW-1:0] y2,
    input  logic          idle1,
    input  logic          idle2,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  a_out,
    output logic [IW-1:0] cnt,
    output logic          dup,
    output logic          err
);

    typedef enum logic {ACC, FULL} state_t;

    localparam logic [IW:0] W_EXT = (IW+1)'(W);

    state_t        state, state_nxt;
    logic [W-1:0]  acc;
    logic          dup_acc, err_acc;
    logic [W-1:0]  mask;
    logic          v1, v2;
    logic          dup_new, err_new;
    logic          accept;

    function automatic logic [IW-1:0] popcnt(input logic [W-1:0] v);
        logic [IW-1:0] pc;
        pc = '0;
        for (int i = 0; i < W; i++) begin
            pc = pc + {{(IW-1){1'b0}}, v[i]};
        end
        return pc;
    endfunction

    assign v1     = !idle1;
    assign v2     = !idle2;
    assign accept = in_valid && in_ready;

    // Out-of-range indices simply match no mask bit; they only raise err.
    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (v1 && y1 == IW'(i)) || (v2 && y2 == IW'(i));
        end
    end

    always_comb begin
        dup_new = ((acc & mask) != '0) || (v1 && v2 && y1 == y2);
        err_new = (v1 && ({1'b0, y1} >= W_EXT))
               || (v2 && ({1'b0, y2} >= W_EXT))
               || (idle1 && v2)
               || (v1 && v2 && (y2 > y1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:  if (accept && in_last) state_nxt = FULL;
            FULL: if (out_ready)         state_nxt = (accept && in_last) ? FULL : ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACC) ? 1'b1 : out_ready;
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            dup_acc <= 1'b0;
            err_acc <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc     <= '0;
                dup_acc <= 1'b0;
                err_acc <= 1'b0;
            end else begin
                acc     <= acc | mask;
                dup_acc <= dup_acc | dup_new;
                err_acc <= err_acc | err_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            cnt   <= '0;
            dup   <= 1'b0;
            err   <= 1'b0;
        end else if (accept && in_last) begin
            a_out <= acc | mask;
            cnt   <= popcnt(acc | mask);
            dup   <= dup_acc | dup_new;
            err   <= err_acc | err_new;
        end
    end

endmodule

// File: tb/tb_pri_dec_2.sv
// Scoreboarded directed bench for pri_dec_2: stimulus pushes expected results, a monitor pops on each output handshake.
module tb_pri_dec_2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] y1 = '0, y2 = '0;
    logic       idle1 = 1'b1, idle2 = 1'b1;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] a_out;
    logic [3:0] cnt;
    logic       dup, err;

    typedef struct packed {
        logic [7:0] a;
        logic [3:0] c;
        logic       d;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pri_dec_2 #(.W(8), .IW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y1(y1), .y2(y2), .idle1(idle1), .idle2(idle2), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .cnt(cnt), .dup(dup), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [7:0] a, input logic [3:0] c, input logic d, input logic e);
        exp_t x;
        x.a = a; x.c = c; x.d = d; x.e = e;
        exp_q.push_back(x);
    endtask

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic beat(input logic [3:0] a1, input logic [3:0] a2,
                        input logic i1, input logic i2, input logic last);
        bit ok;
        ok = 1'b0;
        y1 = a1; y2 = a2; idle1 = i1; idle2 = i2; in_last = last;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready stuck at %0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: a_out=%0h with empty scoreboard, expected none", a_out);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("a_out", {8'h0, a_out}, {8'h0, x.a});
                check("cnt",   {12'h0, cnt},  {12'h0, x.c});
                check("dup",   {15'h0, dup},  {15'h0, x.d});
                check("err",   {15'h0, err},  {15'h0, x.e});
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {15'h0, out_valid}, 16'h0);
        check("rst_a_out",     {8'h0, a_out},      16'h0);
        check("rst_cnt",       {12'h0, cnt},       16'h0);
        check("rst_dup_err",   {14'h0, dup, err},  16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {15'h0, in_ready}, 16'h1);
        @(posedge clk);
        #1;

        // Single-beat vector, one-cycle latency
        expect_res(8'h84, 4'd2, 1'b0, 1'b0);
        beat(4'd7, 4'd2, 1'b0, 1'b0, 1'b1);
        check("lat1_out_valid", {15'h0, out_valid}, 16'h1);

        // Three-beat vector
        expect_res(8'h6B, 4'd5, 1'b0, 1'b0);
        beat(4'd6, 4'd5, 1'b0, 1'b0, 1'b0);
        beat(4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
        check("mid_out_valid", {15'h0, out_valid}, 16'h0);
        beat(4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("lat3_out_valid", {15'h0, out_valid}, 16'h1);

        // Duplicates
        expect_res(8'h10, 4'd1, 1'b1, 1'b0);
        beat(4'd4, 4'd4, 1'b0, 1'b0, 1'b0);
        beat(4'd4, 4'd0, 1'b0, 1'b1, 1'b1);

        // Illegal codes, back-to-back single-beat vectors
        expect_res(8'h08, 4'd1, 1'b0, 1'b1);
        beat(4'd0, 4'd3, 1'b1, 1'b0, 1'b1);
        expect_res(8'h02, 4'd1, 1'b0, 1'b1);
        beat(4'd9, 4'd1, 1'b0, 1'b0, 1'b1);
        expect_res(8'h24, 4'd2, 1'b0, 1'b1);
        beat(4'd2, 4'd5, 1'b0, 1'b0, 1'b1);

        // Stall with a pending last beat, then FULL->FULL handover
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        expect_res(8'h20, 4'd1, 1'b0, 1'b0);
        beat(4'd5, 4'd0, 1'b0, 1'b1, 1'b1);
        y1 = 4'd1; y2 = 4'd0; idle1 = 1'b0; idle2 = 1'b0; in_last = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready",  {15'h0, in_ready},  16'h0);
            check("stall_out_valid", {15'h0, out_valid}, 16'h1);
            check("stall_a_out",     {8'h0, a_out},      16'h20);
        end
        expect_res(8'h03, 4'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_out_valid", {15'h0, out_valid}, 16'h1);
        check("b2b_a_out",     {8'h0, a_out},      16'h03);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-vector
        beat(4'd7, 4'd6, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        check("arst_out_valid", {15'h0, out_valid}, 16'h0);
        check("arst_a_out",     {8'h0, a_out},      16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect_res(8'h01, 4'd1, 1'b0, 1'b0);
        beat(4'd0, 4'd0, 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
